// File: rtl/time_counter_pkg.sv
// Shared types, BCD limits and the packed-BCD increment rule for the time-of-day counter.
package time_counter_pkg;

  typedef logic [7:0] bcd_t;

  localparam bcd_t SEC_MAX   = 8'h59;
  localparam bcd_t MIN_MAX   = 8'h59;
  localparam bcd_t HOUR_MAX  = 8'h23;
  localparam bcd_t BCD_RESET = 8'h00;

  // Out-of-range nibbles (only reachable through upset) fall back to zero.
  function automatic bcd_t bcd_inc(bcd_t v, bcd_t max);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (hi > max[7:4] || (hi == max[7:4] && lo >= max[3:0]))
      return BCD_RESET;
    if (lo >= 4'd9)
      return {hi + 4'd1, 4'd0};
    return {hi, lo + 4'd1};
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Display-side bundle of the time-of-day counter: BCD fields, colon blink and carry pulses.
interface time_counter_if;
  import time_counter_pkg::*;

  bcd_t seconds;
  bcd_t minutes;
  bcd_t hours;
  logic toggle;
  logic min_tick;
  logic hour_tick;

  modport master (output seconds, minutes, hours, toggle, min_tick, hour_tick);
  modport slave  (input  seconds, minutes, hours, toggle, min_tick, hour_tick);
endinterface

// File: rtl/time_counter_bcd_mod_counter.sv
// One packed-BCD field counting 00..MAX; wrap is the combinational carry into the next field.
module bcd_mod_counter
  import time_counter_pkg::*;
#(
  parameter bcd_t MAX = SEC_MAX
) (
  input  logic clk_sec,
  input  logic reset,
  input  logic inc,
  output bcd_t value,
  output logic wrap
);

  assign wrap = inc && (value == MAX);

  always_ff @(posedge clk_sec) begin
    if (reset)
      value <= BCD_RESET;
    else if (inc)
      value <= bcd_inc(value, MAX);
  end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: prescaler to one-second ticks, ripple BCD fields, colon toggle and carry pulses.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic           clk_sec,
  input  logic           reset,
  time_counter_if.master tc
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0] presc;
  logic          sec_tick;
  logic          sec_wrap;
  logic          min_wrap;

  // With one tick per second the prescaler sits at 0 and sec_tick stays high.
  assign sec_tick = (presc == PW'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk_sec) begin
    if (reset) begin
      presc        <= '0;
      tc.toggle    <= 1'b0;
      tc.min_tick  <= 1'b0;
      tc.hour_tick <= 1'b0;
    end else begin
      presc        <= sec_tick ? '0 : presc + 1'b1;
      tc.toggle    <= tc.toggle ^ sec_tick;
      tc.min_tick  <= sec_wrap;
      tc.hour_tick <= min_wrap;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_sec (clk_sec),
    .reset   (reset),
    .inc     (sec_tick),
    .value   (tc.seconds),
    .wrap    (sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_sec (clk_sec),
    .reset   (reset),
    .inc     (sec_wrap),
    .value   (tc.minutes),
    .wrap    (min_wrap)
  );

  // Day rollover needs no carry out of the hours field.
  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk_sec (clk_sec),
    .reset   (reset),
    .inc     (min_wrap),
    .value   (tc.hours),
    .wrap    ()
  );

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a one-tick-per-second and a four-tick-per-second instance against a seconds-count model.
module tb_time_counter;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       tog;
    logic       mt;
    logic       ht;
  } obs_t;

  typedef struct {
    int   t;
    int   p;
    logic tog;
    logic mt;
    logic ht;
  } model_t;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst4 = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  obs_t   q1[$];
  obs_t   q4[$];
  model_t st1 = '{0, 0, 1'b0, 1'b0, 1'b0};
  model_t st4 = '{0, 0, 1'b0, 1'b0, 1'b0};
  obs_t   exp1, exp4;

  time_counter_if if1 ();
  time_counter_if if4 ();

  time_counter #(.TICKS_PER_SEC(1)) dut1 (.clk_sec(clk), .reset(rst1), .tc(if1.master));
  time_counter #(.TICKS_PER_SEC(4)) dut4 (.clk_sec(clk), .reset(rst4), .tc(if4.master));

  obs_t got1, got4;
  assign got1 = {if1.hours, if1.minutes, if1.seconds, if1.toggle, if1.min_tick, if1.hour_tick};
  assign got4 = {if4.hours, if4.minutes, if4.seconds, if4.toggle, if4.min_tick, if4.hour_tick};

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // Model keeps elapsed seconds of the day as a plain integer.
  function automatic model_t model_next(model_t c, logic r, int tps);
    model_t n;
    n = c;
    if (r) begin
      n = '{0, 0, 1'b0, 1'b0, 1'b0};
    end else begin
      n.mt = 1'b0;
      n.ht = 1'b0;
      if (c.p == tps - 1) begin
        n.p   = 0;
        n.tog = ~c.tog;
        if (c.t % 60 == 59) n.mt = 1'b1;
        if (c.t % 3600 == 3599) n.ht = 1'b1;
        n.t = (c.t + 1) % 86400;
      end else begin
        n.p = c.p + 1;
      end
    end
    return n;
  endfunction

  function automatic obs_t model_obs(model_t c);
    return {to_bcd(c.t / 3600), to_bcd((c.t / 60) % 60), to_bcd(c.t % 60), c.tog, c.mt, c.ht};
  endfunction

  task automatic advance();
    st1 = model_next(st1, rst1, 1);
    q1.push_back(model_obs(st1));
    st4 = model_next(st4, rst4, 4);
    q4.push_back(model_obs(st4));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rst4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL reset_tps1 got=%h exp=%h", got1, exp1); end
      checks++;
      if (got4 !== exp4) begin failures++; $display("FAIL reset_tps4 got=%h exp=%h", got4, exp4); end
    end
    checks++;
    if (got1 !== 27'h0) begin failures++; $display("FAIL reset_zero got=%h exp=0", got1); end
  endtask

  task automatic test_tps4();
    int   flips = 0;
    logic prev_tog;
    rst1 = 1'b0;
    rst4 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      prev_tog = if4.toggle;
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL tps4_run_tps1 c=%0d got=%h exp=%h", c, got1, exp1); end
      checks++;
      if (got4 !== exp4) begin failures++; $display("FAIL tps4_run c=%0d got=%h exp=%h", c, got4, exp4); end
      if (if4.toggle !== prev_tog) flips++;
      if (c == 3) begin
        checks++;
        if (if4.seconds !== 8'h00) begin failures++; $display("FAIL tps4_first_tick_early got=%h exp=00", if4.seconds); end
      end
      if (c == 4) begin
        checks++;
        if (if4.seconds !== 8'h01) begin failures++; $display("FAIL tps4_first_tick got=%h exp=01", if4.seconds); end
      end
      if (c == 39) begin
        checks++;
        if (if4.seconds !== 8'h09) begin failures++; $display("FAIL tps4_sec09 got=%h exp=09", if4.seconds); end
      end
    end
    checks++;
    if (if4.seconds !== 8'h10) begin failures++; $display("FAIL tps4_sec10 got=%h exp=10", if4.seconds); end
    checks++;
    if (flips != 10) begin failures++; $display("FAIL tps4_toggle_flips got=%0d exp=10", flips); end
  endtask

  task automatic test_minute();
    int mt_cnt = 0;
    rst1 = 1'b1;
    advance();
    exp1 = q1.pop_front();
    exp4 = q4.pop_front();
    checks++;
    if (got1 !== 27'h0) begin failures++; $display("FAIL minute_rearm got=%h exp=0", got1); end
    rst1 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL minute_run c=%0d got=%h exp=%h", c, got1, exp1); end
      checks++;
      if (got4 !== exp4) begin failures++; $display("FAIL minute_run_tps4 c=%0d got=%h exp=%h", c, got4, exp4); end
      if (if1.min_tick === 1'b1) mt_cnt++;
    end
    checks++;
    if ({if1.hours, if1.minutes, if1.seconds, if1.toggle} !== {8'h00, 8'h01, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL minute_value got=%h:%h:%h tog=%b exp=00:01:00 tog=0", if1.hours, if1.minutes, if1.seconds, if1.toggle);
    end
    checks++;
    if (mt_cnt != 1) begin failures++; $display("FAIL minute_tick_count got=%0d exp=1", mt_cnt); end
  endtask

  task automatic test_hour();
    int both = 0;
    for (int c = 61; c <= 3600; c++) begin
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL hour_run c=%0d got=%h exp=%h", c, got1, exp1); end
      checks++;
      if (got4 !== exp4) begin failures++; $display("FAIL hour_run_tps4 c=%0d got=%h exp=%h", c, got4, exp4); end
      if (if1.min_tick === 1'b1 && if1.hour_tick === 1'b1) both++;
    end
    checks++;
    if ({if1.hours, if1.minutes, if1.seconds} !== {8'h01, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL hour_value got=%h:%h:%h exp=01:00:00", if1.hours, if1.minutes, if1.seconds);
    end
    checks++;
    if (both != 1) begin failures++; $display("FAIL hour_tick_pair got=%0d exp=1", both); end
  endtask

  task automatic test_day_rollover();
    for (int c = 3601; c <= 86400; c++) begin
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL day_run c=%0d got=%h exp=%h", c, got1, exp1); end
      checks++;
      if (got4 !== exp4) begin failures++; $display("FAIL day_run_tps4 c=%0d got=%h exp=%h", c, got4, exp4); end
      if (c == 86399) begin
        checks++;
        if ({if1.hours, if1.minutes, if1.seconds} !== {8'h23, 8'h59, 8'h59}) begin
          failures++;
          $display("FAIL day_last_second got=%h:%h:%h exp=23:59:59", if1.hours, if1.minutes, if1.seconds);
        end
      end
    end
    checks++;
    if ({if1.hours, if1.minutes, if1.seconds, if1.min_tick, if1.hour_tick} !== {24'h000000, 2'b11}) begin
      failures++;
      $display("FAIL day_rollover got=%h:%h:%h mt=%b ht=%b exp=00:00:00 mt=1 ht=1",
               if1.hours, if1.minutes, if1.seconds, if1.min_tick, if1.hour_tick);
    end
  endtask

  task automatic test_reset_midcount();
    for (int c = 1; c <= 9; c++) begin
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL mid_run c=%0d got=%h exp=%h", c, got1, exp1); end
    end
    checks++;
    if (if1.seconds !== 8'h09) begin failures++; $display("FAIL mid_sec09 got=%h exp=09", if1.seconds); end
    rst1 = 1'b1;
    advance();
    exp1 = q1.pop_front();
    exp4 = q4.pop_front();
    checks++;
    if (got1 !== 27'h0) begin failures++; $display("FAIL mid_reset got=%h exp=0", got1); end
    rst1 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      advance();
      exp1 = q1.pop_front();
      exp4 = q4.pop_front();
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL mid_resume c=%0d got=%h exp=%h", c, got1, exp1); end
      checks++;
      if (got4 !== exp4) begin failures++; $display("FAIL mid_resume_tps4 c=%0d got=%h exp=%h", c, got4, exp4); end
    end
    checks++;
    if (if1.seconds !== 8'h03) begin failures++; $display("FAIL mid_resume_value got=%h exp=03", if1.seconds); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tps4();
    test_minute();
    test_hour();
    test_day_rollover();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
